// File: rtl/nand_chk_pkg.sv
// Shared types and limits for the NAND response checker.
// Holds the run-state encoding and the largest supported DUT latency.
package nand_chk_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } chk_state_t;

  localparam int MAX_LAT = 7;
  localparam int DRAIN_W = $clog2(MAX_LAT + 1);

endpackage

// File: rtl/nand_exp_pipe.sv
// LAT-stage delay line of {valid, expected Y, vector index}; LAT==0 is a pass-through.
// Shifts every cycle with no backpressure; clr drops all in-flight entries.
module nand_exp_pipe #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8,
  parameter int LAT   = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             in_vld,
  input  logic [WIDTH-1:0] in_exp,
  input  logic [CNT_W-1:0] in_idx,
  output logic             out_vld,
  output logic [WIDTH-1:0] out_exp,
  output logic [CNT_W-1:0] out_idx
);

  // One stage is always built so LAT==0 still elaborates cleanly; it is bypassed.
  localparam int DEPTH = (LAT == 0) ? 1 : LAT;

  logic             vld_q [DEPTH];
  logic [WIDTH-1:0] exp_q [DEPTH];
  logic [CNT_W-1:0] idx_q [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        vld_q[i] <= 1'b0;
        exp_q[i] <= '0;
        idx_q[i] <= '0;
      end
    end else begin
      vld_q[0] <= in_vld & ~clr;
      exp_q[0] <= in_exp;
      idx_q[0] <= in_idx;
      for (int i = 1; i < DEPTH; i++) begin
        vld_q[i] <= vld_q[i-1] & ~clr;
        exp_q[i] <= exp_q[i-1];
        idx_q[i] <= idx_q[i-1];
      end
    end
  end

  assign out_vld = (LAT == 0) ? in_vld : vld_q[DEPTH-1];
  assign out_exp = (LAT == 0) ? in_exp : exp_q[DEPTH-1];
  assign out_idx = (LAT == 0) ? in_idx : idx_q[DEPTH-1];

endmodule

// File: rtl/nand_resp_checker.sv
// Compares NAND DUT output against ~(A&B) after a fixed LAT, counting vectors/errors per run.
// Results land one edge after each compare; no backpressure, vec_valid outside RUN is dropped.
module nand_resp_checker
  import nand_chk_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int LAT     = 0,
  parameter int NUM_VEC = 3,
  parameter int CNT_W   = 8,
  parameter int ERR_W   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             vec_valid,
  input  logic [WIDTH-1:0] vec_a,
  input  logic [WIDTH-1:0] vec_b,
  input  logic [WIDTH-1:0] dut_y,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] vec_cnt,
  output logic [ERR_W-1:0] err_cnt,
  output logic [CNT_W-1:0] first_err_idx,
  output logic [WIDTH-1:0] first_err_y,
  output logic [WIDTH-1:0] err_bits
);

  localparam logic [CNT_W-1:0]   LAST_IDX   = CNT_W'(NUM_VEC - 1);
  localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'((LAT == 0) ? 0 : LAT - 1);

  chk_state_t         state_q;
  logic [DRAIN_W-1:0] drain_cnt_q;

  logic             start_ok;
  logic             accept;
  logic             last_acc;
  logic             cmp_vld;
  logic             mism;
  logic [WIDTH-1:0] exp_y;
  logic [WIDTH-1:0] cmp_exp;
  logic [WIDTH-1:0] diff;
  logic [CNT_W-1:0] cmp_idx;

  assign start_ok = start && (state_q == IDLE || state_q == DONE);
  assign accept   = vec_valid && (state_q == RUN);
  assign last_acc = accept && (vec_cnt == LAST_IDX);
  assign exp_y    = ~(vec_a & vec_b);

  nand_exp_pipe #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W),
    .LAT   (LAT)
  ) u_pipe (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (start_ok),
    .in_vld  (accept),
    .in_exp  (exp_y),
    .in_idx  (vec_cnt),
    .out_vld (cmp_vld),
    .out_exp (cmp_exp),
    .out_idx (cmp_idx)
  );

  assign busy = (state_q == RUN) || (state_q == DRAIN);
  assign done = (state_q == DONE);
  assign pass = done && (err_cnt == '0);
  assign diff = dut_y ^ cmp_exp;
  assign mism = cmp_vld && busy && (diff != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      drain_cnt_q <= '0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start) state_q <= RUN;
        end
        RUN: begin
          if (last_acc) begin
            state_q     <= (LAT == 0) ? DONE : DRAIN;
            drain_cnt_q <= '0;
          end
        end
        DRAIN: begin
          // The last accepted vector emerges from the delay line on the LAT-th DRAIN cycle.
          if (drain_cnt_q == DRAIN_LAST) state_q <= DONE;
          else                           drain_cnt_q <= drain_cnt_q + DRAIN_W'(1);
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vec_cnt       <= '0;
      err_cnt       <= '0;
      first_err_idx <= '0;
      first_err_y   <= '0;
      err_bits      <= '0;
    end else if (start_ok) begin
      vec_cnt       <= '0;
      err_cnt       <= '0;
      first_err_idx <= '0;
      first_err_y   <= '0;
      err_bits      <= '0;
    end else begin
      if (accept) vec_cnt <= vec_cnt + CNT_W'(1);
      if (mism) begin
        if (err_cnt != {ERR_W{1'b1}}) err_cnt <= err_cnt + ERR_W'(1);
        if (err_cnt == '0) begin
          first_err_idx <= cmp_idx;
          first_err_y   <= dut_y;
        end
        err_bits <= err_bits | diff;
      end
    end
  end

endmodule
